// File: rtl/rf_wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rf_wb_pkg                                                 |
// | Brief    : Shared constants and types for the register-file          |
// |            writeback arbiter.                                        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package rf_wb_pkg;

   // Default geometry of the register file write port
   localparam int DEF_AW       = 5;
   localparam int DEF_DW       = 32;
   localparam int DEF_MAX_WAIT = 4;

   // Architectural zero register: writes to it are consumed but dropped
   localparam int RF_ZERO_ADDR = 0;

   // Identifiers reported on rf_wsrc
   localparam logic WB_SRC_P0 = 1'b0;
   localparam logic WB_SRC_P1 = 1'b1;

   // Arbitration mode
   typedef enum logic {
      NORMAL = 1'b0,
      STARVE = 1'b1
   } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/rf_wb_starve_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rf_wb_starve_ctr                                          |
// | Brief    : Counts consecutive denied port-1 cycles and switches the  |
// |            arbiter into STARVE mode once MAX_WAIT is reached, until  |
// |            port 1 completes a transfer.                              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module rf_wb_starve_ctr
   import rf_wb_pkg::*;
#(
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic clk,
   input  logic rstn,
   input  logic p1_valid,
   input  logic p1_grant,
   output logic starve
);

   localparam int            CW    = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] C_MAX = CW'(MAX_WAIT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   wb_state_e     state_q;
   logic          starve_q;

   // Next counter value: clear on port-1 transfer, saturating count while waiting
   always_comb begin
      cnt_d = cnt_q;
      if (p1_grant) begin
         cnt_d = '0;
      end else if (p1_valid && (cnt_q != C_MAX)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter and mode FSM with registered starve flag
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q    <= '0;
         state_q  <= NORMAL;
         starve_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         case (state_q)
            NORMAL: begin
               if (cnt_d == C_MAX) begin
                  state_q  <= STARVE;
                  starve_q <= 1'b1;
               end
            end
            STARVE: begin
               if (p1_grant) begin
                  state_q  <= NORMAL;
                  starve_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= NORMAL;
               starve_q <= 1'b0;
            end
         endcase
      end
   end

   assign starve = starve_q;

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rf_wb_arbiter                                             |
// | Brief    : Arbitrates the single register-file write port between a  |
// |            fixed-priority port 0 and an anti-starvation port 1, and  |
// |            registers the winning write. Define RF_WB_BYPASS_EN to    |
// |            add write-to-read forwarding for two read ports.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          p0_valid,
   output logic          p0_ready,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_data,
   input  logic          p1_valid,
   output logic          p1_ready,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_data,
`ifdef RF_WB_BYPASS_EN
   input  logic [AW-1:0] rd_addr1,
   input  logic [AW-1:0] rd_addr2,
   input  logic [DW-1:0] rf_rd1,
   input  logic [DW-1:0] rf_rd2,
   output logic [DW-1:0] fwd_rd1,
   output logic [DW-1:0] fwd_rd2,
`endif
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic          rf_wsrc,
   output logic          starved
);

   localparam logic [AW-1:0] ZERO_ADDR = AW'(RF_ZERO_ADDR);

   logic          starve;
   logic          p0_xfer;
   logic          p1_xfer;
   logic          we_q;
   logic [AW-1:0] waddr_q;
   logic [DW-1:0] wdata_q;
   logic          wsrc_q;

   rf_wb_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_ctr (
      .clk      (clk),
      .rstn     (rstn),
      .p1_valid (p1_valid),
      .p1_grant (p1_xfer),
      .starve   (starve)
   );

   // Grant selection: port 0 wins normally, port 1 wins while starving
   always_comb begin
      p0_ready = 1'b0;
      p1_ready = 1'b0;
      if (rstn) begin
         if (starve) begin
            p1_ready = p1_valid;
            p0_ready = p0_valid && !p1_valid;
         end else begin
            p0_ready = p0_valid;
            p1_ready = p1_valid && !p0_valid;
         end
      end
   end

   assign p0_xfer = p0_valid && p0_ready;
   assign p1_xfer = p1_valid && p1_ready;

   // Output register: capture the winning write, suppress the strobe for x0
   always_ff @(posedge clk) begin
      if (!rstn) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         wsrc_q  <= WB_SRC_P0;
      end else if (p0_xfer) begin
         we_q    <= (p0_addr != ZERO_ADDR);
         waddr_q <= p0_addr;
         wdata_q <= p0_data;
         wsrc_q  <= WB_SRC_P0;
      end else if (p1_xfer) begin
         we_q    <= (p1_addr != ZERO_ADDR);
         waddr_q <= p1_addr;
         wdata_q <= p1_data;
         wsrc_q  <= WB_SRC_P1;
      end else begin
         we_q    <= 1'b0;
      end
   end

   assign rf_we    = we_q;
   assign rf_waddr = waddr_q;
   assign rf_wdata = wdata_q;
   assign rf_wsrc  = wsrc_q;
   assign starved  = starve;

`ifdef RF_WB_BYPASS_EN
   // Forward the value being written this cycle to matching readers
   always_comb begin
      fwd_rd1 = rf_rd1;
      fwd_rd2 = rf_rd2;
      if (we_q && (waddr_q == rd_addr1) && (rd_addr1 != ZERO_ADDR)) begin
         fwd_rd1 = wdata_q;
      end
      if (we_q && (waddr_q == rd_addr2) && (rd_addr2 != ZERO_ADDR)) begin
         fwd_rd2 = wdata_q;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_rf_wb_arbiter                                          |
// | Brief    : Directed self-checking bench for rf_wb_arbiter. Define    |
// |            RF_WB_BYPASS_EN to also exercise the forwarding ports.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_rf_wb_arbiter;

   localparam int AW       = 5;
   localparam int DW       = 32;
   localparam int MAX_WAIT = 4;

   logic          clk;
   logic          rstn;
   logic          p0_valid;
   logic          p0_ready;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_data;
   logic          p1_valid;
   logic          p1_ready;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_data;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          rf_wsrc;
   logic          starved;
`ifdef RF_WB_BYPASS_EN
   logic [AW-1:0] rd_addr1;
   logic [AW-1:0] rd_addr2;
   logic [DW-1:0] rf_rd1;
   logic [DW-1:0] rf_rd2;
   logic [DW-1:0] fwd_rd1;
   logic [DW-1:0] fwd_rd2;
`endif

   int n_total = 0;
   int n_bad   = 0;

   rf_wb_arbiter #(
      .AW       (AW),
      .DW       (DW),
      .MAX_WAIT (MAX_WAIT)
   ) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .p0_valid (p0_valid),
      .p0_ready (p0_ready),
      .p0_addr  (p0_addr),
      .p0_data  (p0_data),
      .p1_valid (p1_valid),
      .p1_ready (p1_ready),
      .p1_addr  (p1_addr),
      .p1_data  (p1_data),
`ifdef RF_WB_BYPASS_EN
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .rf_rd1   (rf_rd1),
      .rf_rd2   (rf_rd2),
      .fwd_rd1  (fwd_rd1),
      .fwd_rd2  (fwd_rd2),
`endif
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .rf_wsrc  (rf_wsrc),
      .starved  (starved)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Requesters must hold valid/addr/data stable until granted
   logic          pend0, pend1;
   logic [AW-1:0] hold_a0, hold_a1;
   logic [DW-1:0] hold_d0, hold_d1;
   initial begin
      pend0 = 1'b0;
      pend1 = 1'b0;
   end
   always @(posedge clk) begin
      if (!rstn) begin
         pend0 = 1'b0;
         pend1 = 1'b0;
      end else begin
         if (pend0 && !(p0_valid && p0_addr == hold_a0 && p0_data == hold_d0)) begin
            n_bad++;
            $display("FAIL p0_hold: valid=%0b addr=%0d want held addr=%0d", p0_valid, p0_addr, hold_a0);
         end
         if (pend1 && !(p1_valid && p1_addr == hold_a1 && p1_data == hold_d1)) begin
            n_bad++;
            $display("FAIL p1_hold: valid=%0b addr=%0d want held addr=%0d", p1_valid, p1_addr, hold_a1);
         end
         pend0   = p0_valid && !p0_ready;
         pend1   = p1_valid && !p1_ready;
         hold_a0 = p0_addr;
         hold_d0 = p0_data;
         hold_a1 = p1_addr;
         hold_d1 = p1_data;
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn     = 1'b0;
      p0_valid = 1'b1;
      p0_addr  = 5'd2;
      p0_data  = 32'h0000_0222;
      p1_valid = 1'b1;
      p1_addr  = 5'd6;
      p1_data  = 32'h0000_0666;
`ifdef RF_WB_BYPASS_EN
      rd_addr1 = '0;
      rd_addr2 = '0;
      rf_rd1   = '0;
      rf_rd2   = '0;
`endif

      // Reset held 3 cycles with both requesters valid
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("rst_p0_ready", 32'(p0_ready), 32'd0);
         check_eq("rst_p1_ready", 32'(p1_ready), 32'd0);
      end
      rstn     = 1'b1;
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      #1;
      check_eq("rst_rf_we",    32'(rf_we),    32'd0);
      check_eq("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      check_eq("rst_rf_wdata", rf_wdata,      32'd0);
      check_eq("rst_rf_wsrc",  32'(rf_wsrc),  32'd0);
      check_eq("rst_starved",  32'(starved),  32'd0);

      // Single port-0 write
      p0_valid = 1'b1;
      p0_addr  = 5'd5;
      p0_data  = 32'hDEAD_BEEF;
      #1;
      check_eq("wr_p0_ready", 32'(p0_ready), 32'd1);
      check_eq("wr_p1_ready", 32'(p1_ready), 32'd0);
      step();
      p0_valid = 1'b0;
      check_eq("wr_rf_we",    32'(rf_we),    32'd1);
      check_eq("wr_rf_waddr", 32'(rf_waddr), 32'd5);
      check_eq("wr_rf_wdata", rf_wdata,      32'hDEAD_BEEF);
      check_eq("wr_rf_wsrc",  32'(rf_wsrc),  32'd0);
      step();
      check_eq("idle_rf_we",    32'(rf_we),    32'd0);
      check_eq("idle_rf_waddr", 32'(rf_waddr), 32'd5);

      // Continuous contention: 4 port-0 grants, then 1 port-1 grant, repeating
      p0_valid = 1'b1;
      p0_addr  = 5'd3;
      p0_data  = 32'h0000_0300;
      p1_valid = 1'b1;
      p1_addr  = 5'd4;
      p1_data  = 32'h0000_0400;
      for (int k = 0; k < 10; k++) begin
         #1;
         check_eq("ct_starved",  32'(starved),  (k % 5 == 4) ? 32'd1 : 32'd0);
         check_eq("ct_p0_ready", 32'(p0_ready), (k % 5 == 4) ? 32'd0 : 32'd1);
         check_eq("ct_p1_ready", 32'(p1_ready), (k % 5 == 4) ? 32'd1 : 32'd0);
         step();
         if (k == 9) p1_valid = 1'b0;
         check_eq("ct_rf_we",    32'(rf_we),    32'd1);
         check_eq("ct_rf_wsrc",  32'(rf_wsrc),  (k % 5 == 4) ? 32'd1 : 32'd0);
         check_eq("ct_rf_waddr", 32'(rf_waddr), (k % 5 == 4) ? 32'd4 : 32'd3);
         check_eq("ct_rf_wdata", rf_wdata,      (k % 5 == 4) ? 32'h400 : 32'h300);
      end
      #1;
      check_eq("ct_end_starved",  32'(starved),  32'd0);
      check_eq("ct_end_p0_ready", 32'(p0_ready), 32'd1);
      step();
      p0_valid = 1'b0;
      check_eq("ct_end_rf_wsrc", 32'(rf_wsrc), 32'd0);

      // Port-1 write to x0 is consumed without a write strobe
      p1_valid = 1'b1;
      p1_addr  = 5'd0;
      p1_data  = 32'h0000_1234;
      #1;
      check_eq("x0_p1_ready", 32'(p1_ready), 32'd1);
      step();
      p1_valid = 1'b0;
      check_eq("x0_rf_we",    32'(rf_we),   32'd0);
      check_eq("x0_rf_wsrc",  32'(rf_wsrc), 32'd1);
      check_eq("x0_rf_wdata", rf_wdata,     32'h0000_1234);

      // Reset in the middle of a contended sequence
      p0_valid = 1'b1;
      p0_addr  = 5'd7;
      p0_data  = 32'h0000_0077;
      p1_valid = 1'b1;
      p1_addr  = 5'd8;
      p1_data  = 32'h0000_0088;
      step();
      check_eq("mid_rf_we",    32'(rf_we),    32'd1);
      check_eq("mid_rf_waddr", 32'(rf_waddr), 32'd7);
      rstn = 1'b0;
      #1;
      check_eq("mid_rst_p0_ready", 32'(p0_ready), 32'd0);
      check_eq("mid_rst_p1_ready", 32'(p1_ready), 32'd0);
      step();
      rstn = 1'b1;
      check_eq("mid_rst_rf_we",   32'(rf_we),   32'd0);
      check_eq("mid_rst_starved", 32'(starved), 32'd0);
      // Counter restarted from 0: port 1 waits a full four cycles again
      for (int k = 0; k < 5; k++) begin
         #1;
         check_eq("post_p1_ready", 32'(p1_ready), (k == 4) ? 32'd1 : 32'd0);
         step();
         if (k == 4) p1_valid = 1'b0;
         check_eq("post_rf_wsrc", 32'(rf_wsrc), (k == 4) ? 32'd1 : 32'd0);
      end
      step();
      p0_valid = 1'b0;
      step();

`ifdef RF_WB_BYPASS_EN
      // Forwarding of the in-flight write to both read ports
      p0_valid = 1'b1;
      p0_addr  = 5'd9;
      p0_data  = 32'hA5A5_A5A5;
      step();
      p0_valid = 1'b0;
      rd_addr1 = 5'd9;
      rf_rd1   = 32'h0000_0009;
      rd_addr2 = 5'd10;
      rf_rd2   = 32'h0000_0010;
      #1;
      check_eq("byp_fwd_rd1",    fwd_rd1, 32'hA5A5_A5A5);
      check_eq("byp_fwd_rd2",    fwd_rd2, 32'h0000_0010);
      step();
      check_eq("byp_after_rd1",  fwd_rd1, 32'h0000_0009);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
